// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
// Optional multiply support is selected in alu_seq by ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic v;
    logic z;
    logic c;
    logic s;
  } flags_t;

  // Opcodes 8..11 are the serial shift/rotate group.
  function automatic logic is_shift(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Combinational v/z/c/s generation shared by the single-cycle and serial paths.
// s is set for a non-negative result to match the core's branch decode.
module alu_flags
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH:0]   res_i,
  output logic             v_o,
  output logic             z_o,
  output logic             c_o,
  output logic             s_o
);

  logic a_msb_s, b_msb_s, r_msb_s;

  assign a_msb_s = a_i[WIDTH-1];
  assign b_msb_s = b_i[WIDTH-1];
  assign r_msb_s = res_i[WIDTH-1];

  // Carry/borrow and signed overflow only for the add/sub group.
  always_comb begin
    v_o = 1'b0;
    c_o = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        c_o = res_i[WIDTH];
        v_o = (a_msb_s == b_msb_s) && (r_msb_s != a_msb_s);
      end
      OP_SUB: begin
        c_o = res_i[WIDTH];
        v_o = (a_msb_s != b_msb_s) && (r_msb_s != a_msb_s);
      end
      OP_CMP: begin
        c_o = res_i[WIDTH];
        v_o = 1'b0;
      end
      default: begin
        v_o = 1'b0;
        c_o = 1'b0;
      end
    endcase
  end

  assign z_o = (res_i[WIDTH-1:0] == '0);
  assign s_o = ~r_msb_s;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, serial 1-bit/cycle shifter,
// optional iterative multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] dipswitch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] prod_s;
`endif

  logic [SHW-1:0]   k_s;
  logic [WIDTH:0]   sum_s, diff_s, alu_res_s, f_res_s;
  logic [WIDTH-1:0] step_s;
  logic [3:0]       f_op_s;
  logic             f_v_s, f_z_s, f_c_s, f_s_s;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] w);
    case (op)
      OP_SLL:  shift1 = {w[WIDTH-2:0], 1'b0};
      OP_ROL:  shift1 = {w[WIDTH-2:0], w[WIDTH-1]};
      OP_SRL:  shift1 = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  shift1 = {w[WIDTH-1], w[WIDTH-1:1]};
      default: shift1 = w;
    endcase
  endfunction

  assign k_s    = in2[SHW-1:0];
  assign sum_s  = {1'b0, in1} + {1'b0, in2};
  assign diff_s = {1'b0, in1} - {1'b0, in2};
  assign step_s = shift1(op_q, wrk_q);

  // Single-cycle result, evaluated on the live operands in the accept cycle.
  always_comb begin
    alu_res_s = '0;
    case (opcode)
      OP_ADD:                         alu_res_s = sum_s;
      OP_SUB, OP_CMP:                 alu_res_s = diff_s;
      OP_AND:                         alu_res_s = {1'b0, in1 & in2};
      OP_OR:                          alu_res_s = {1'b0, in1 | in2};
      OP_XOR:                         alu_res_s = {1'b0, in1 ^ in2};
      OP_MOV:                         alu_res_s = {1'b0, in1};
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: alu_res_s = {1'b0, in1};
      OP_IN:                          alu_res_s = {1'b0, dipswitch};
      default:                        alu_res_s = '0;
    endcase
  end

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .opcode_i (f_op_s),
    .a_i      (in1),
    .b_i      (in2),
    .res_i    (f_res_s),
    .v_o      (f_v_s),
    .z_o      (f_z_s),
    .c_o      (f_c_s),
    .s_o      (f_s_s)
  );

  // Next-state and datapath updates; the flag unit input follows the active path.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wrk_d    = wrk_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    f_op_s   = opcode;
    f_res_s  = alu_res_s;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mpl_d    = mpl_q;
    prod_s   = acc_q + (mpl_q[0] ? wrk_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = opcode;
          if (is_shift(opcode) && (k_s != '0)) begin
            wrk_d   = in1;
            cnt_d   = {1'b0, k_s};
            state_d = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (opcode == OP_MUL) begin
            wrk_d   = in1;
            mpl_d   = in2;
            acc_d   = '0;
            cnt_d   = (SHW+1)'(WIDTH);
            state_d = MUL;
`endif
          end else begin
            result_d = alu_res_s[WIDTH-1:0];
            flags_d  = {f_v_s, f_z_s, f_c_s, f_s_s};
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        f_op_s  = op_q;
        f_res_s = {1'b0, step_s};
        wrk_d   = step_s;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = step_s;
          flags_d  = {f_v_s, f_z_s, f_c_s, f_s_s};
          state_d  = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        f_op_s  = op_q;
        f_res_s = {1'b0, prod_s};
        acc_d   = prod_s;
        wrk_d   = {wrk_q[WIDTH-2:0], 1'b0};
        mpl_d   = {1'b0, mpl_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = prod_s;
          flags_d  = {f_v_s, f_z_s, f_c_s, f_s_s};
          state_d  = DONE;
        end else begin
          state_d = MUL;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      wrk_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mpl_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wrk_q    <= wrk_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mpl_q    <= mpl_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == MUL);
  assign result    = result_q;
  assign v         = flags_q.v;
  assign z         = flags_q.z;
  assign c         = flags_q.c;
  assign s         = flags_q.s;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16); define ALU_SEQ_MUL_EN to cover MUL.
module tb_alu_seq;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;   // {v,z,c,s}
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] in1 = 16'd0, in2 = 16'd0, dipswitch = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        v, z, c, s, busy;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in1(in1), .in2(in2), .dipswitch(dipswitch),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .v(v), .z(z), .c(c), .s(s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] dip);
    exp_t e;
    logic [16:0] full;
    int k, sa, sb, sr;
    e.lat = 1;
    e.res = 16'd0;
    e.fl  = 4'd0;
    full  = 17'd0;
    k  = int'(b[3:0]);
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0: begin
        full = {1'b0, a} + {1'b0, b}; e.res = full[15:0]; sr = sa + sb;
        e.fl[3] = (sr > 32767) || (sr < -32768); e.fl[1] = full[16];
      end
      4'd1: begin
        full = {1'b0, a} - {1'b0, b}; e.res = full[15:0]; sr = sa - sb;
        e.fl[3] = (sr > 32767) || (sr < -32768); e.fl[1] = full[16];
      end
      4'd5: begin
        full = {1'b0, a} - {1'b0, b}; e.res = full[15:0]; e.fl[1] = full[16];
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd6: e.res = a;
      4'd12: e.res = dip;
      4'd8: begin e.res = a << k; e.lat = k + 1; end
      4'd9: begin e.res = (k == 0) ? a : ((a << k) | (a >> (16 - k))); e.lat = k + 1; end
      4'd10: begin e.res = a >> k; e.lat = k + 1; end
      4'd11: begin e.res = $unsigned($signed(a) >>> k); e.lat = k + 1; end
`ifdef ALU_SEQ_MUL_EN
      4'd7: begin e.res = 16'(32'(a) * 32'(b)); e.lat = 17; end
`endif
      default: e.res = 16'd0;
    endcase
    e.fl[2] = (e.res == 16'd0);
    e.fl[0] = ~e.res[15];
    return e;
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the output handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] dip, input int bp);
    exp_t e;
    int n;
    bit seen;
    logic [15:0] hold_res;
    logic [3:0]  hold_fl;
    check_eq({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    opcode = op; in1 = a; in2 = b; dipswitch = dip; in_valid = 1'b1;
    sb_q.push_back(model(op, a, b, dip));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 4'($urandom); in1 = 16'($urandom); in2 = 16'($urandom); dipswitch = 16'($urandom);
    n = 1;
    seen = out_valid;
    while (!seen && n < 40) begin
      check_eq({tag, "/busy"}, 32'(busy), 32'd1);
      check_eq({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    if (!seen) begin
      check_eq({tag, "/out_valid_timeout"}, 32'(out_valid), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      check_eq({tag, "/sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, "/result"}, 32'(result), 32'(e.res));
    check_eq({tag, "/flags"}, 32'({v, z, c, s}), 32'(e.fl));
    check_eq({tag, "/latency"}, 32'(n), 32'(e.lat));
    hold_res = result;
    hold_fl  = {v, z, c, s};
    for (int i = 0; i < bp; i++) begin
      in_valid = (i == 1 || i == 3);
      opcode = 4'd0; in1 = 16'h1111; in2 = 16'h2222;
      @(negedge clk);
      check_eq({tag, "/bp_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "/bp_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, "/bp_result"}, 32'(result), 32'(e.res));
      check_eq({tag, "/bp_flags"}, 32'({v, z, c, s}), 32'(e.fl));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "/post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "/post_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "/post_result"}, 32'(result), 32'(hold_res));
    check_eq({tag, "/post_flags"}, 32'({v, z, c, s}), 32'(hold_fl));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst/in_ready", 32'(in_ready), 32'd1);
    check_eq("rst/out_valid", 32'(out_valid), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/result", 32'(result), 32'd0);
    check_eq("rst/flags", 32'({v, z, c, s}), 32'd0);

    run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h0, 0);
    run_op("sub_borrow", 4'd1, 16'h0000, 16'h0001, 16'h0, 0);
    run_op("cmp_eq", 4'd5, 16'h1234, 16'h1234, 16'h0, 0);
    run_op("sra3", 4'd11, 16'h8000, 16'h0003, 16'h0, 0);
    run_op("sll_k0", 4'd8, 16'hBEEF, 16'h0010, 16'h0, 0);
    run_op("rol4", 4'd9, 16'h8001, 16'h0004, 16'h0, 0);
    run_op("srl15", 4'd10, 16'h8000, 16'h000F, 16'h0, 0);
    run_op("xor_bp", 4'd4, 16'hF0F0, 16'h0FF0, 16'h0, 5);
    run_op("and", 4'd2, 16'hF0F0, 16'h3C3C, 16'h0, 0);
    run_op("or", 4'd3, 16'h8000, 16'h0001, 16'h0, 0);
    run_op("mov", 4'd6, 16'h0000, 16'h5555, 16'h0, 0);
    run_op("in", 4'd12, 16'h1234, 16'h5678, 16'hA5A5, 0);
    run_op("op7", 4'd7, 16'h00FF, 16'h0101, 16'h0, 0);
    run_op("op13", 4'd13, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);

    // Abort a long shift with reset in its third serial cycle.
    opcode = 4'd8; in1 = 16'h0001; in2 = 16'h000F; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort/out_valid", 32'(out_valid), 32'd0);
    check_eq("abort/in_ready", 32'(in_ready), 32'd1);
    check_eq("abort/busy", 32'(busy), 32'd0);
    check_eq("abort/result", 32'(result), 32'd0);
    run_op("add_after_rst", 4'd0, 16'd2, 16'd3, 16'h0, 0);

    for (int i = 0; i < 12; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
